credit_ctrl: RTL and testbench

CREDIT_CTRL -- requirements
Module: credit_ctrl

---
 rtl/credit_pkg.sv | 24 ++
 rtl/edge_det.sv | 21 ++
 rtl/credit_ctrl.sv | 114 +++++++++++
 tb/tb_credit_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/credit_pkg.sv
// Shared definitions for the laundry credit controller: FSM encoding,
// default pricing/limit constants and button bit positions.
package credit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_LAUNCH  = 2'd2
   } state_t;

   localparam int DEF_NUM_MACH   = 4;
   localparam int DEF_CREDIT_W   = 4;
   localparam int DEF_MAX_CREDIT = 9;
   localparam int DEF_PRICE_LO   = 1;
   localparam int DEF_PRICE_HI   = 2;
   localparam logic [3:0] DEF_DRYER_MASK = 4'b1000;

   // Bit positions of the buttons inside the packed button-edge vector.
   localparam int BTN_U = 0;
   localparam int BTN_D = 1;
   localparam int BTN_C = 2;
   localparam int BTN_L = 3;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector: pulses for one cycle when an input bit is high now
// and was low on the previous clock.
module edge_det #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] rise
);

   logic [W-1:0] prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev <= '0;
      else        prev <= din;
   end

   assign rise = din & ~prev;

endmodule

// File: rtl/credit_ctrl.sv
// Coin-credit controller for a bank of washers/dryers: collects coins,
// launches the selected channel on "go", refunds on cancel, tracks completion.
module credit_ctrl
   import credit_pkg::*;
#(
   parameter int NUM_MACH   = DEF_NUM_MACH,
   parameter int CREDIT_W   = DEF_CREDIT_W,
   parameter int MAX_CREDIT = DEF_MAX_CREDIT,
   parameter int PRICE_LO   = DEF_PRICE_LO,
   parameter int PRICE_HI   = DEF_PRICE_HI,
   parameter logic [NUM_MACH-1:0] DRYER_MASK = NUM_MACH'(DEF_DRYER_MASK)
) (
   input  logic                CLK100MHZ,
   input  logic                CPU_RESETN,
   input  logic [NUM_MACH-1:0] SW,
   input  logic                BTNU,
   input  logic                BTND,
   input  logic                BTNC,
   input  logic                BTNL,
   input  logic                hi_sel,
   input  logic [NUM_MACH-1:0] cycle_done,
   output logic [CREDIT_W-1:0] credit,
   output logic [NUM_MACH-1:0] start,
   output logic [NUM_MACH-1:0] hi_temp,
   output logic [NUM_MACH-1:0] busy,
   output logic [NUM_MACH-1:0] LED,
   output logic [CREDIT_W-1:0] refund,
   output logic                refund_vld,
   output logic                err,
   output state_t              fsm_state
);

   localparam int SUM_W = CREDIT_W + 2;

   state_t              state;
   logic [3:0]          btn_rise;
   logic [NUM_MACH-1:0] done_rise;

   edge_det #(.W(4)) u_btn_edge (
      .clk   (CLK100MHZ),
      .rst_n (CPU_RESETN),
      .din   ({BTNL, BTNC, BTND, BTNU}),
      .rise  (btn_rise)
   );

   edge_det #(.W(NUM_MACH)) u_done_edge (
      .clk   (CLK100MHZ),
      .rst_n (CPU_RESETN),
      .din   (cycle_done),
      .rise  (done_rise)
   );

   logic               sel_ok, eff_hi, open_st, do_cancel, go_ok, go_bad;
   logic               coin_any, coin_over, refund_now;
   logic [SUM_W-1:0]   credit_ext, price, coin_sum, base, credit_nxt;
   logic [NUM_MACH-1:0] done_hit, launch_vec;

   // A dryer always runs hot and is charged the high price whatever hi_sel says.
   always_comb begin
      sel_ok     = $onehot(SW) && ((SW & busy) == '0);
      eff_hi     = hi_sel || ((SW & DRYER_MASK) != '0);
      credit_ext = SUM_W'(credit);
      price      = eff_hi ? SUM_W'(PRICE_HI) : SUM_W'(PRICE_LO);
      coin_sum   = (btn_rise[BTN_U] ? SUM_W'(PRICE_LO) : '0) +
                   (btn_rise[BTN_D] ? SUM_W'(PRICE_HI) : '0);
      open_st    = (state != ST_LAUNCH);
      do_cancel  = btn_rise[BTN_L] && open_st;
      refund_now = do_cancel && (credit != '0);
      go_ok      = btn_rise[BTN_C] && !do_cancel && (state == ST_COLLECT) &&
                   sel_ok && (price <= credit_ext);
      go_bad     = btn_rise[BTN_C] && !do_cancel && open_st && !go_ok;
      base       = go_ok ? (credit_ext - price) : credit_ext;
      coin_any   = (coin_sum != '0) && open_st;
      coin_over  = (base + coin_sum) > SUM_W'(MAX_CREDIT);
      credit_nxt = base;
      if (do_cancel)                   credit_nxt = '0;
      else if (coin_any && !coin_over) credit_nxt = base + coin_sum;
      done_hit   = done_rise & busy;
      launch_vec = go_ok ? SW : '0;
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state      <= ST_IDLE;
         credit     <= '0;
         start      <= '0;
         hi_temp    <= '0;
         busy       <= '0;
         LED        <= '0;
         refund     <= '0;
         refund_vld <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE:    if (sel_ok) state <= ST_COLLECT;
            ST_COLLECT: if (!sel_ok)    state <= ST_IDLE;
                        else if (go_ok) state <= ST_LAUNCH;
            default:    state <= ST_COLLECT;
         endcase
         credit     <= credit_nxt[CREDIT_W-1:0];
         start      <= launch_vec;
         busy       <= (busy & ~done_hit) | launch_vec;
         LED        <= (LED | done_hit) & ~launch_vec;
         if (go_ok)
            hi_temp <= (hi_temp & ~SW) | (eff_hi ? SW : '0);
         refund     <= refund_now ? credit : '0;
         refund_vld <= refund_now;
         err        <= go_bad || (coin_any && (do_cancel || coin_over));
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_credit_ctrl.sv
// Directed bench for credit_ctrl: a rule-level reference model checked every
// cycle plus hand-computed literal expectations for each scenario.
module tb_credit_ctrl;
   import credit_pkg::*;

   localparam int PLO = 1;
   localparam int PHI = 2;
   localparam int MAXC = 9;
   localparam logic [3:0] DRY = 4'b1000;
   localparam int M_IDLE = 0, M_COLLECT = 1, M_LAUNCH = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] sw = '0;
   logic       btnu = 0, btnd = 0, btnc = 0, btnl = 0, hi_sel = 0;
   logic [3:0] cycle_done = '0;
   logic [3:0] credit, start, hi_temp, busy, led, refund;
   logic       refund_vld, err;
   state_t     dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   logic [3:0] done_r = '0;

   credit_ctrl dut (
      .CLK100MHZ (clk),
      .CPU_RESETN(rst_n),
      .SW        (sw),
      .BTNU      (btnu),
      .BTND      (btnd),
      .BTNC      (btnc),
      .BTNL      (btnl),
      .hi_sel    (hi_sel),
      .cycle_done(cycle_done),
      .credit    (credit),
      .start     (start),
      .hi_temp   (hi_temp),
      .busy      (busy),
      .LED       (led),
      .refund    (refund),
      .refund_vld(refund_vld),
      .err       (err),
      .fsm_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: expected outputs after each active edge.
   int         m_credit, m_refund, m_mode;
   logic [3:0] m_busy, m_led, m_hi, m_start;
   logic       m_rvld, m_err;
   logic       pu, pd, pc, pl;
   logic [3:0] pdone;
   logic       ue, de, ce, le, ok, effhi, open_st, launch;
   logic [3:0] dn_e, hits;
   int         price, coins, nc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_credit = 0; m_refund = 0; m_mode = M_IDLE;
         m_busy = 0; m_led = 0; m_hi = 0; m_start = 0;
         m_rvld = 0; m_err = 0;
         pu = 0; pd = 0; pc = 0; pl = 0; pdone = 0;
      end else begin
         ue = btnu && !pu; de = btnd && !pd; ce = btnc && !pc; le = btnl && !pl;
         dn_e = cycle_done & ~pdone;
         pu = btnu; pd = btnd; pc = btnc; pl = btnl; pdone = cycle_done;
         ok      = ($countones(sw) == 1) && ((sw & m_busy) == 0);
         effhi   = hi_sel || ((sw & DRY) != 0);
         price   = effhi ? PHI : PLO;
         coins   = (ue ? PLO : 0) + (de ? PHI : 0);
         open_st = (m_mode != M_LAUNCH);
         nc = m_credit; m_err = 0; m_rvld = 0; m_refund = 0; launch = 0;
         if (le && open_st) begin
            if (m_credit > 0) begin
               m_refund = m_credit; m_rvld = 1; nc = 0;
            end
            if (coins > 0) m_err = 1;
         end else begin
            if (ce && open_st) begin
               if (m_mode == M_COLLECT && ok && price <= m_credit) begin
                  launch = 1; nc = nc - price;
               end else m_err = 1;
            end
            if (coins > 0 && open_st) begin
               if (nc + coins > MAXC) m_err = 1;
               else nc = nc + coins;
            end
         end
         m_credit = nc;
         hits = dn_e & m_busy;
         m_busy = m_busy & ~hits;
         m_led  = m_led | hits;
         m_start = launch ? sw : 4'b0;
         if (launch) begin
            m_busy = m_busy | sw;
            m_led  = m_led & ~sw;
            m_hi   = effhi ? (m_hi | sw) : (m_hi & ~sw);
         end
         case (m_mode)
            M_IDLE:    m_mode = ok ? M_COLLECT : M_IDLE;
            M_COLLECT: m_mode = !ok ? M_IDLE : (launch ? M_LAUNCH : M_COLLECT);
            default:   m_mode = M_COLLECT;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("credit", int'(credit), m_credit);
      chk("start", int'(start), int'(m_start));
      chk("hi_temp", int'(hi_temp), int'(m_hi));
      chk("busy", int'(busy), int'(m_busy));
      chk("led", int'(led), int'(m_led));
      chk("refund", int'(refund), m_refund);
      chk("refund_vld", int'(refund_vld), int'(m_rvld));
      chk("err", int'(err), int'(m_err));
   end

   // Called at negedge+1: drive one cycle of inputs, return at next negedge+1.
   task automatic cyc(input logic [3:0] s, input logic u, input logic d,
                      input logic c, input logic l, input logic h,
                      input logic [3:0] dn);
      sw = s; btnu = u; btnd = d; btnc = c; btnl = l; hi_sel = h;
      done_r = dn; cycle_done = dn;
      @(negedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] s, input logic u, input logic d,
                        input logic c, input logic l, input logic h);
      cyc(s, u, d, c, l, h, done_r);
      cyc(s, 0, 0, 0, 0, h, done_r);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_credit", int'(credit), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_state", int'(dbg_state), int'(ST_IDLE));
      #1 rst_n = 1'b1;

      // Low coin + high coin, hot wash on channel 0.
      cyc(4'b0001, 0, 0, 0, 0, 1, 4'b0000);
      press(4'b0001, 1, 0, 0, 0, 1);
      press(4'b0001, 0, 1, 0, 0, 1);
      chk("s1_credit3", int'(credit), 3);
      cyc(4'b0001, 0, 0, 1, 0, 1, 4'b0000);
      chk("s1_credit1", int'(credit), 1);
      chk("s1_start", int'(start), 4'b0001);
      chk("s1_busy", int'(busy), 4'b0001);
      chk("s1_hi", int'(hi_temp), 4'b0001);
      chk("s1_state", int'(dbg_state), int'(ST_LAUNCH));
      cyc(4'b0001, 0, 0, 0, 0, 1, 4'b0000);
      chk("s1_start_end", int'(start), 0);

      // Dryer: 1 credit is not enough, 2 credits launch hot.
      cyc(4'b1000, 0, 0, 0, 0, 0, 4'b0000);
      cyc(4'b1000, 0, 0, 1, 0, 0, 4'b0000);
      chk("s2_err", int'(err), 1);
      chk("s2_nostart", int'(start), 0);
      chk("s2_credit1", int'(credit), 1);
      cyc(4'b1000, 0, 0, 0, 0, 0, 4'b0000);
      press(4'b1000, 1, 0, 0, 0, 0);
      cyc(4'b1000, 0, 0, 1, 0, 0, 4'b0000);
      chk("s2_start", int'(start), 4'b1000);
      chk("s2_hi", int'(hi_temp), 4'b1001);
      chk("s2_credit0", int'(credit), 0);
      cyc(4'b1000, 0, 0, 0, 0, 0, 4'b0000);

      // Channel 1 cold, then channels 0 and 1 complete together.
      cyc(4'b0010, 0, 0, 0, 0, 0, 4'b0000);
      press(4'b0010, 1, 0, 0, 0, 0);
      cyc(4'b0010, 0, 0, 1, 0, 0, 4'b0000);
      chk("s3_busy", int'(busy), 4'b1011);
      cyc(4'b0010, 0, 0, 0, 0, 0, 4'b0000);
      cyc(4'b0010, 0, 0, 0, 0, 0, 4'b0011);
      chk("s3_busy_done", int'(busy), 4'b1000);
      chk("s3_led", int'(led), 4'b0011);
      cyc(4'b0001, 0, 0, 0, 0, 0, 4'b0011);
      press(4'b0001, 1, 0, 0, 0, 0);
      cyc(4'b0001, 0, 0, 1, 0, 0, 4'b0011);
      chk("s3_led_relaunch", int'(led), 4'b0010);
      chk("s3_hi_cold", int'(hi_temp), 4'b1000);
      cyc(4'b0001, 0, 0, 0, 0, 0, 4'b0011);
      cyc(4'b0001, 0, 0, 0, 0, 0, 4'b0111);
      chk("s3_idle_done_led", int'(led), 4'b0010);
      chk("s3_idle_done_busy", int'(busy), 4'b1001);
      cyc(4'b0001, 0, 0, 0, 0, 0, 4'b0000);

      // Saturation at 9.
      cyc(4'b0100, 0, 0, 0, 0, 0, 4'b0000);
      repeat (4) press(4'b0100, 0, 1, 0, 0, 0);
      chk("s4_credit8", int'(credit), 8);
      cyc(4'b0100, 0, 1, 0, 0, 0, 4'b0000);
      chk("s4_over_err", int'(err), 1);
      chk("s4_over_credit", int'(credit), 8);
      cyc(4'b0100, 0, 0, 0, 0, 0, 4'b0000);
      press(4'b0100, 1, 0, 0, 0, 0);
      chk("s4_credit9", int'(credit), 9);
      cyc(4'b0100, 1, 0, 0, 0, 0, 4'b0000);
      chk("s4_full_err", int'(err), 1);
      chk("s4_full_credit", int'(credit), 9);
      cyc(4'b0100, 0, 0, 0, 0, 0, 4'b0000);

      // Refunds, including cancel racing a coin and cancel with nothing owed.
      cyc(4'b0100, 0, 0, 0, 1, 0, 4'b0000);
      chk("s5_refund9", int'(refund), 9);
      chk("s5_rvld", int'(refund_vld), 1);
      chk("s5_credit0", int'(credit), 0);
      cyc(4'b0100, 0, 0, 0, 0, 0, 4'b0000);
      chk("s5_rvld_end", int'(refund_vld), 0);
      press(4'b0100, 0, 1, 0, 0, 0);
      press(4'b0100, 0, 1, 0, 0, 0);
      press(4'b0100, 1, 0, 0, 0, 0);
      chk("s5_credit5", int'(credit), 5);
      cyc(4'b0100, 1, 0, 0, 1, 0, 4'b0000);
      chk("s5_refund5", int'(refund), 5);
      chk("s5_rvld5", int'(refund_vld), 1);
      chk("s5_cancel_coin_err", int'(err), 1);
      chk("s5_cancel_credit", int'(credit), 0);
      cyc(4'b0100, 0, 0, 0, 0, 0, 4'b0000);
      cyc(4'b0100, 0, 0, 0, 1, 0, 4'b0000);
      chk("s5_zero_cancel", int'(refund_vld), 0);
      cyc(4'b0100, 0, 0, 0, 0, 0, 4'b0000);

      // Go while idle.
      cyc(4'b0000, 0, 0, 0, 0, 0, 4'b0000);
      chk("s6_idle", int'(dbg_state), int'(ST_IDLE));
      cyc(4'b0000, 0, 0, 1, 0, 0, 4'b0000);
      chk("s6_idle_go_err", int'(err), 1);
      cyc(4'b0000, 0, 0, 0, 0, 0, 4'b0000);

      // Both coins at once, then coin together with a valid go.
      cyc(4'b0100, 0, 0, 0, 0, 1, 4'b0000);
      press(4'b0100, 1, 1, 0, 0, 1);
      chk("s7_credit3", int'(credit), 3);
      cyc(4'b0100, 0, 1, 1, 0, 1, 4'b0000);
      chk("s7_go_coin_credit", int'(credit), 3);
      chk("s7_start", int'(start), 4'b0100);
      chk("s7_hi", int'(hi_temp), 4'b1100);
      cyc(4'b0100, 0, 0, 0, 0, 1, 4'b0000);
      cyc(4'b0100, 0, 0, 0, 0, 1, 4'b0000);
      press(4'b0100, 1, 0, 0, 0, 1);
      chk("s7_credit4", int'(credit), 4);
      chk("s7_busy", int'(busy), 4'b1101);

      // Reset mid-operation.
      sw = 0; btnu = 0; btnd = 0; btnc = 0; btnl = 0; hi_sel = 0; cycle_done = 0;
      rst_n = 1'b0;
      #1;
      chk("s8_credit", int'(credit), 0);
      chk("s8_busy", int'(busy), 0);
      chk("s8_led", int'(led), 0);
      chk("s8_hi", int'(hi_temp), 0);
      chk("s8_rvld", int'(refund_vld), 0);
      chk("s8_state", int'(dbg_state), int'(ST_IDLE));
      @(negedge clk);
      #1;
      chk("s8_rvld_hold", int'(refund_vld), 0);
      rst_n = 1'b1;
      cyc(4'b0000, 0, 0, 0, 0, 0, 4'b0000);
      cyc(4'b0000, 0, 0, 0, 0, 0, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
